alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_if.sv | 22 ++
 rtl/alu.sv | 101 ++++++++++
 tb/tb_alu.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// rtl/alu_if.sv - ALU operand/result bundle with driver and ALU-side views
interface alu_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] op;
    logic [3:0] out;
    logic       cout;
    logic       overflow;
    logic       zero;

    // Side that supplies operands and observes the registered result
    modport master (
        output A, B, op,
        input  out, cout, overflow, zero
    );

    // The ALU itself
    modport slave (
        input  A, B, op,
        output out, cout, overflow, zero
    );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - 4-bit registered ALU, eight ops, carry/overflow/zero flags
module alu (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] out,
    output logic       cout,
    output logic       overflow,
    output logic       zero,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] op
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [3:0] out_q, out_d;
    logic       cout_q, cout_d;
    logic       overflow_q, overflow_d;
    logic       zero_q, zero_d;

    logic [4:0] add_sum;
    logic [4:0] sub_sum;
    logic       add_ovf;
    logic       sub_ovf;
    logic       a_lt_b_signed;

    // Shared arithmetic: subtraction goes through A + ~B + 1 so its carry is the no-borrow flag
    always_comb begin
        add_sum = {1'b0, A} + {1'b0, B};
        sub_sum = {1'b0, A} + {1'b0, ~B} + 5'd1;
        // Signed overflow: add when operand signs agree but result sign differs;
        // subtract when operand signs differ and result sign departs from A
        add_ovf = (A[3] == B[3]) && (add_sum[3] != A[3]);
        sub_ovf = (A[3] != B[3]) && (sub_sum[3] != A[3]);
        // Signed compare taken from the true sign of A-B, i.e. sign xor overflow
        a_lt_b_signed = sub_sum[3] ^ sub_ovf;
    end

    // Next-state result and flags; every op code has a defined result
    always_comb begin
        out_d      = 4'b0000;
        cout_d     = 1'b0;
        overflow_d = 1'b0;
        unique case (op)
            OP_ADD: begin
                out_d      = add_sum[3:0];
                cout_d     = add_sum[4];
                overflow_d = add_ovf;
            end
            OP_SUB: begin
                out_d      = sub_sum[3:0];
                cout_d     = sub_sum[4];
                overflow_d = sub_ovf;
            end
            OP_AND: out_d = A & B;
            OP_OR:  out_d = A | B;
            OP_XOR: out_d = A ^ B;
            OP_NOT: out_d = ~A;
            OP_SHL: begin
                out_d  = {A[2:0], 1'b0};
                cout_d = A[3];
            end
            OP_SLT: out_d = {3'b000, a_lt_b_signed};
            default: begin
                out_d      = 4'b0000;
                cout_d     = 1'b0;
                overflow_d = 1'b0;
            end
        endcase
        // Zero derives from the value being registered so it never lags out
        zero_d = (out_d == 4'b0000);
    end

    // Result register: reset wins, otherwise capture a new result every edge
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= 4'b0000;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            out_q      <= out_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign out      = out_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for the 4-bit registered ALU
module tb_alu;

    logic clk;
    logic rst;
    alu_if bus ();

    alu u_dut (
        .clk      (clk),
        .rst      (rst),
        .out      (bus.out),
        .cout     (bus.cout),
        .overflow (bus.overflow),
        .zero     (bus.zero),
        .A        (bus.A),
        .B        (bus.B),
        .op       (bus.op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] out;
        logic       cout;
        logic       ovf;
        logic       zero;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input exp_t e, input string phase);
        n_checks++;
        if (bus.out === e.out && bus.cout === e.cout &&
            bus.overflow === e.ovf && bus.zero === e.zero) begin
            n_pass++;
        end else begin
            $display("FAIL %s (%s): got out=%b cout=%b ovf=%b zero=%b, want out=%b cout=%b ovf=%b zero=%b",
                     name, phase, bus.out, bus.cout, bus.overflow, bus.zero,
                     e.out, e.cout, e.ovf, e.zero);
        end
    endtask

    // Monitor: one registered result per edge; re-check late in the cycle to
    // confirm outputs hold while the inputs are disturbed
    initial begin
        exp_t cur;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check(cur.name, cur, "edge");
                #3;
                check(cur.name, cur, "hold");
            end
        end
    end

    // Drive one vector before an edge, then scramble inputs after it
    task automatic apply(input string name, input logic r, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] o,
                         input logic [3:0] eo, input logic ec, input logic ev,
                         input logic ez);
        exp_t e;
        @(negedge clk);
        rst    = r;
        bus.A  = a;
        bus.B  = b;
        bus.op = o;
        e.name = name; e.out = eo; e.cout = ec; e.ovf = ev; e.zero = ez;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        bus.A  = ~a;
        bus.B  = b + 4'd3;
        bus.op = o + 3'd1;
    endtask

    initial begin
        int budget;
        rst    = 1'b1;
        bus.A  = 4'b0000;
        bus.B  = 4'b0000;
        bus.op = 3'b000;

        //     name          rst A        B        op      out      c     v     z
        apply("reset",       1, 4'b0110, 4'b0011, 3'b000, 4'b0000, 0, 0, 1);

        apply("9p10_add",    0, 4'b1001, 4'b1010, 3'b000, 4'b0011, 1, 1, 0);
        apply("9p10_sub",    0, 4'b1001, 4'b1010, 3'b001, 4'b1111, 0, 0, 0);
        apply("9p10_and",    0, 4'b1001, 4'b1010, 3'b010, 4'b1000, 0, 0, 0);
        apply("9p10_or",     0, 4'b1001, 4'b1010, 3'b011, 4'b1011, 0, 0, 0);
        apply("9p10_xor",    0, 4'b1001, 4'b1010, 3'b100, 4'b0011, 0, 0, 0);
        apply("9p10_slt",    0, 4'b1001, 4'b1010, 3'b111, 4'b0001, 0, 0, 0);

        apply("3p15_add",    0, 4'b0011, 4'b1111, 3'b000, 4'b0010, 1, 0, 0);
        apply("3p15_sub",    0, 4'b0011, 4'b1111, 3'b001, 4'b0100, 0, 0, 0);
        apply("3p15_not",    0, 4'b0011, 4'b1111, 3'b101, 4'b1100, 0, 0, 0);
        apply("3p15_slt",    0, 4'b0011, 4'b1111, 3'b111, 4'b0000, 0, 0, 1);

        apply("12p8_add",    0, 4'b1100, 4'b1000, 3'b000, 4'b0100, 1, 1, 0);
        apply("12p8_sub",    0, 4'b1100, 4'b1000, 3'b001, 4'b0100, 1, 0, 0);
        apply("12p8_shl",    0, 4'b1100, 4'b1000, 3'b110, 4'b1000, 1, 0, 0);
        apply("12p8_and",    0, 4'b1100, 4'b1000, 3'b010, 4'b1000, 0, 0, 0);

        apply("7p1_add",     0, 4'b0111, 4'b0001, 3'b000, 4'b1000, 0, 1, 0);
        apply("5m5_sub",     0, 4'b0101, 4'b0101, 3'b001, 4'b0000, 1, 0, 1);

        // Reset mid-stream for two edges, then resume
        apply("rst_hold1",   1, 4'b1111, 4'b0001, 3'b000, 4'b0000, 0, 0, 1);
        apply("rst_hold2",   1, 4'b1111, 4'b0001, 3'b000, 4'b0000, 0, 0, 1);
        apply("rst_release", 0, 4'b1111, 4'b0001, 3'b000, 4'b0000, 1, 0, 1);

        // Back-to-back sweep through every op code (A=0110, B=1011)
        apply("sw_add",      0, 4'b0110, 4'b1011, 3'b000, 4'b0001, 1, 0, 0);
        apply("sw_sub",      0, 4'b0110, 4'b1011, 3'b001, 4'b1011, 0, 1, 0);
        apply("sw_and",      0, 4'b0110, 4'b1011, 3'b010, 4'b0010, 0, 0, 0);
        apply("sw_or",       0, 4'b0110, 4'b1011, 3'b011, 4'b1111, 0, 0, 0);
        apply("sw_xor",      0, 4'b0110, 4'b1011, 3'b100, 4'b1101, 0, 0, 0);
        apply("sw_not",      0, 4'b0110, 4'b1011, 3'b101, 4'b1001, 0, 0, 0);
        apply("sw_shl",      0, 4'b0110, 4'b1011, 3'b110, 4'b1100, 0, 0, 0);
        apply("sw_slt",      0, 4'b0110, 4'b1011, 3'b111, 4'b0000, 0, 0, 1);
        apply("slt_true",    0, 4'b1000, 4'b0111, 3'b111, 4'b0001, 0, 0, 0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
